bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_to_bin_seq_pkg.sv | 36 +++
 rtl/bcd_sub3_adj.sv | 21 ++
 rtl/bcd_to_bin_seq.sv | 193 +++++++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq_pkg
//   Shared constants, FSM state encoding and small helpers for the sequential
//   BCD-to-binary converter (reverse double-dabble).
// ---------------------------------------------------------------------------
package bcd_to_bin_seq_pkg;

  // Width of one BCD digit.
  localparam int BCD_NIBBLE = 4;

  // Largest legal decimal digit value.
  localparam logic [BCD_NIBBLE-1:0] DIGIT_MAX = 4'd9;

  // Reverse double-dabble correction: after a right shift, a digit that
  // reads 8 or more received a "ten" (worth 16/2 = 8) from its upper
  // neighbour, which must be worth 5. Subtracting 3 fixes it.
  localparam logic [BCD_NIBBLE-1:0] ADJ_THRESH = 4'd8;
  localparam logic [BCD_NIBBLE-1:0] ADJ_SUB    = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Per-digit correction used by every digit slice.
  function automatic logic [BCD_NIBBLE-1:0] sub3_adj(input logic [BCD_NIBBLE-1:0] n);
    return (n >= ADJ_THRESH) ? (n - ADJ_SUB) : n;
  endfunction

  // True when a nibble does not hold a decimal digit.
  function automatic logic nibble_illegal(input logic [BCD_NIBBLE-1:0] n);
    return (n > DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_sub3_adj.sv
// ---------------------------------------------------------------------------
// bcd_sub3_adj
//   Combinational per-digit correction for reverse double-dabble:
//   nib_out = (nib_in >= 8) ? nib_in - 3 : nib_in. No borrow leaves the digit.
//
// Ports:
//   nib_in   in  4  digit value after the right shift
//   nib_out  out 4  corrected digit value
// ---------------------------------------------------------------------------
module bcd_sub3_adj
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] nib_in,
  output logic [BCD_NIBBLE-1:0] nib_out
);

  always_comb begin
    nib_out = sub3_adj(nib_in);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//   Sequential BCD-to-binary converter. A {bcd, W'b0} register is shifted
//   right once per cycle and every digit nibble is then corrected
//   (>=8 -> -3). After W steps the low W bits hold the binary value.
//   Valid/ready handshake on both sides; one conversion in flight at a time.
//
//   Timing: accept edge loads the register, W edges perform the steps and
//   one more edge latches the result, so out_valid rises W+1 edges after
//   the accept edge.
//
// Optional feature (macro BCD_DIGIT_CHECK_EN):
//   defined   - a nibble > 9 on the accept edge makes the result err=1,
//               bin_out=0, delivered with the normal latency/handshake.
//   undefined - no check; err is constant 0.
//
// Ports:
//   clock      in   1          system clock
//   reset      in   1          asynchronous, active-high reset
//   in_valid   in   1          BCD word presented
//   in_ready   out  1          converter idle, can accept
//   bcd_in     in   4*DIGITS   packed digits, MSD in the top nibble
//   out_valid  out  1          result available
//   out_ready  in   1          consumer accepts result
//   bin_out    out  W          binary result
//   busy       out  1          conversion in progress
//   err        out  1          illegal input digit, qualified by out_valid
// ---------------------------------------------------------------------------
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int W      = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BCD_NIBBLE*DIGITS-1:0] bcd_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 bin_out,
  output logic                         busy,
  output logic                         err
);

  localparam int BW = BCD_NIBBLE * DIGITS;  // BCD field width
  localparam int SW = BW + W;               // whole shift register width
  localparam int CW = $clog2(W + 1);        // step counter width

`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e          state_q,     state_d;
  logic [SW-1:0]   sr_q,        sr_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [W-1:0]    bin_q,       bin_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q,  in_ready_d;
  logic            busy_q,      busy_d;
  logic            err_q,       err_d;
  logic            bad_q,       bad_d;   // illegal digit seen on accept

  // -------------------------------------------------------------------------
  // One reverse double-dabble step: shift right, then correct each digit.
  // -------------------------------------------------------------------------
  logic [SW-1:0] sr_shift;
  logic [SW-1:0] sr_step;

  assign sr_shift          = sr_q >> 1;
  assign sr_step[W-1:0]    = sr_shift[W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_sub3_adj u_adj (
      .nib_in  (sr_shift[W + g*BCD_NIBBLE +: BCD_NIBBLE]),
      .nib_out (sr_step [W + g*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end

  // Any illegal digit in the word being presented.
  logic bcd_bad;
  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (nibble_illegal(bcd_in[i*BCD_NIBBLE +: BCD_NIBBLE])) bcd_bad = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned; without these defaults synthesis would infer latches.
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    err_d       = err_q;
    bad_d       = bad_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sr_d       = {bcd_in, {W{1'b0}}};
          cnt_d      = CW'(W);
          bad_d      = CHECK_EN ? bcd_bad : 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end

      CONV: begin
        if (cnt_q == '0) begin
          // All W steps done: present the result (forced to 0 on error).
          bin_d       = bad_q ? '0 : sr_q[W-1:0];
          err_d       = bad_q;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end else begin
          sr_d  = sr_step;
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          err_d       = 1'b0;
          bad_d       = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        err_d       = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. Reset clears the datapath too, so an interrupted conversion
  // can never leak partial bits into a later result.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      bad_q       <= bad_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//   Directed self-checking bench for bcd_to_bin_seq (DIGITS=3, W=10).
//   Honours BCD_DIGIT_CHECK_EN for the illegal-digit expectations.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

  localparam int DIGITS  = 3;
  localparam int W       = 10;
  localparam int LATENCY = W + 1;

  logic                 clock;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DIGITS-1:0]  bcd_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         bin_out;
  logic                 busy;
  logic                 err;

  int n_pass  = 0;
  int n_total = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .busy      (busy),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction. hold = cycles out_ready stays low after completion
  // (0 means out_ready is high throughout). chk_bin=0 skips the value check.
  task automatic run_conv(input string tag, input logic [11:0] bcd,
                          input logic [W-1:0] exp_bin, input bit chk_bin,
                          input logic exp_err, input int hold);
    int n;
    check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    bcd_in    = bcd;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();                       // accept edge
    in_valid = 1'b0;
    bcd_in   = ~bcd;              // must not affect the result
    check({tag, ":busy"},      32'(busy),      32'd1);
    check({tag, ":in_ready0"}, 32'(in_ready),  32'd0);
    check({tag, ":no_early"},  32'(out_valid), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(LATENCY));
    if (chk_bin) check({tag, ":bin"}, 32'(bin_out), 32'(exp_bin));
    check({tag, ":err"},  32'(err),  32'(exp_err));
    check({tag, ":busy_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;            // must be ignored outside IDLE
      bcd_in   = 12'h777;
      tick();
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_rdy"},   32'(in_ready),  32'd0);
      if (chk_bin) check({tag, ":hold_bin"}, 32'(bin_out), 32'(exp_bin));
      check({tag, ":hold_err"},   32'(err),       32'(exp_err));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();                       // handshake edge
    check({tag, ":ov_clear"},  32'(out_valid), 32'd0);
    check({tag, ":rdy_back"},  32'(in_ready),  32'd1);
    check({tag, ":err_clear"}, 32'(err),       32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] d2, d1, d0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = '0;
    #12;
    check("rst:in_ready",  32'(in_ready),  32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:busy",      32'(busy),      32'd0);
    check("rst:err",       32'(err),       32'd0);
    check("rst:bin",       32'(bin_out),   32'd0);
    reset = 1'b0;
    tick();

    // Basic conversions, out_ready high throughout (DONE lasts one cycle).
    run_conv("c255", 12'h255, 10'd255, 1'b1, 1'b0, 0);
    run_conv("c999", 12'h999, 10'd999, 1'b1, 1'b0, 0);
    run_conv("c000", 12'h000, 10'd0,   1'b1, 1'b0, 0);
    run_conv("c100", 12'h100, 10'd100, 1'b1, 1'b0, 0);
    run_conv("c009", 12'h009, 10'd9,   1'b1, 1'b0, 0);

    // Backpressure: 20 cycles with out_ready low.
    run_conv("bp437", 12'h437, 10'd437, 1'b1, 1'b0, 20);

    // Async reset in the middle of a conversion.
    bcd_in   = 12'h888;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst:in_ready",  32'(in_ready),  32'd1);
    check("mid_rst:out_valid", 32'(out_valid), 32'd0);
    check("mid_rst:busy",      32'(busy),      32'd0);
    check("mid_rst:bin",       32'(bin_out),   32'd0);
    check("mid_rst:err",       32'(err),       32'd0);
    #4 reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("mid_rst:no_result", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    run_conv("c042", 12'h042, 10'd42, 1'b1, 1'b0, 0);

    // Illegal digit handling.
`ifdef BCD_DIGIT_CHECK_EN
    run_conv("bad1A3", 12'h1A3, 10'd0, 1'b1, 1'b1, 3);
`else
    run_conv("bad1A3", 12'h1A3, 10'd0, 1'b0, 1'b0, 3);
`endif
    run_conv("c123", 12'h123, 10'd123, 1'b1, 1'b0, 0);

    // Random legal inputs against a decimal reference.
    for (int k = 0; k < 300; k++) begin
      d2 = 4'($urandom_range(0, 9));
      d1 = 4'($urandom_range(0, 9));
      d0 = 4'($urandom_range(0, 9));
      run_conv("rnd", {d2, d1, d0},
               10'(32'(d2) * 100 + 32'(d1) * 10 + 32'(d0)),
               1'b1, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
